// File: rtl/btb_pkg.sv
// -----------------------------------------------------------------------------
// btb_pkg
// Shared definitions for the branch target buffer:
//   - MIPS opcode / funct constants for control-flow decode
//   - 2-bit saturating counter type and its update function
//   - instruction class enum produced by btb_target_calc
// Optional feature macro (used by branch_target_buffer): BTB_JR_PREDICT_EN
// -----------------------------------------------------------------------------
package btb_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    typedef enum logic [1:0] {
        CLS_NONE,   // not a control instruction
        CLS_COND,   // BEQ/BNE/BLEZ/BGTZ/REGIMM
        CLS_JUMP,   // J/JAL
        CLS_JREG    // JR/JALR
    } instr_cls_t;

    function automatic ctr_t ctr_step(input ctr_t c, input logic taken);
        ctr_t n;
        n = c;
        case (c)
            SNT: n = taken ? WNT : SNT;
            WNT: n = taken ? WT  : SNT;
            WT:  n = taken ? ST  : WNT;
            ST:  n = taken ? ST  : WT;
            default: n = c;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/btb_target_calc.sv
// -----------------------------------------------------------------------------
// btb_target_calc
// Combinational decode of a resolved instruction: classifies it and computes
// the architectural target, the actual taken outcome and the actual next PC.
// Ports:
//   pc       in  32  address of the instruction
//   instr    in  32  instruction word
//   rs_data  in  32  rs operand (register-jump target)
//   taken_in in  1   reported outcome (only meaningful for conditionals)
//   cls      out     instruction class
//   target   out 32  architectural target
//   taken    out 1   actual outcome (1 for any jump, 0 for non-control)
//   next_pc  out 32  target if taken, else pc+8 (past the delay slot)
// -----------------------------------------------------------------------------
module btb_target_calc
    import btb_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic        taken_in,
    output instr_cls_t  cls,
    output logic [31:0] target,
    output logic        taken,
    output logic [31:0] next_pc
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc_plus4;
    logic [31:0] br_offset;

    assign opcode    = instr[31:26];
    assign funct     = instr[5:0];
    assign pc_plus4  = pc + 32'd4;
    assign br_offset = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        cls    = CLS_NONE;
        target = '0;
        case (opcode)
            OP_J, OP_JAL: begin
                cls    = CLS_JUMP;
                target = {pc_plus4[31:28], instr[25:0], 2'b00};
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
                cls    = CLS_COND;
                target = pc_plus4 + br_offset;
            end
            OP_SPECIAL: begin
                if (funct == FN_JR || funct == FN_JALR) begin
                    cls    = CLS_JREG;
                    target = rs_data;
                end
            end
            default: begin
                cls    = CLS_NONE;
                target = '0;
            end
        endcase
    end

    always_comb begin
        case (cls)
            CLS_COND: taken = taken_in;
            CLS_JUMP: taken = 1'b1;
            CLS_JREG: taken = 1'b1;
            default:  taken = 1'b0;
        endcase
    end

    assign next_pc = taken ? target : (pc + 32'd8);

endmodule

// File: rtl/branch_target_buffer.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
// Direct-mapped BTB with 2-bit counters. Fetch lookups give a registered
// prediction one cycle later; EX updates train the table and raise a
// registered one-cycle redirect on misprediction.
// Optional feature macro: BTB_JR_PREDICT_EN (JR/JALR allocate like J/JAL;
// otherwise they never allocate and invalidate a hitting entry).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   fetch_valid, fetch_pc          lookup request
//   pred_hit/taken/target          registered lookup result
//   upd_valid, upd_pc, upd_instr,
//   upd_rs_data, upd_taken,
//   upd_pred_taken, upd_pred_target  resolved instruction from EX
//   redirect_valid, redirect_pc    registered mispredict redirect
// -----------------------------------------------------------------------------
module branch_target_buffer
    import btb_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        pred_hit,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_instr,
    input  logic [31:0] upd_rs_data,
    input  logic        upd_taken,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    ctr_t               ctr_q    [ENTRIES];

    // Lookup side
    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;
    logic             l_hit;
    logic             l_taken;

    assign l_idx   = fetch_pc[IDX_W+1:2];
    assign l_tag   = fetch_pc[31:IDX_W+2];
    assign l_hit   = fetch_valid && valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign l_taken = l_hit && ctr_q[l_idx][1];

    logic unused_fetch_lsb;
    assign unused_fetch_lsb = ^fetch_pc[1:0];

    // Update side
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;

    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[31:IDX_W+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    instr_cls_t  cls;
    logic [31:0] calc_target;
    logic        act_taken;
    logic [31:0] act_next_pc;

    btb_target_calc u_calc (
        .pc       (upd_pc),
        .instr    (upd_instr),
        .rs_data  (upd_rs_data),
        .taken_in (upd_taken),
        .cls      (cls),
        .target   (calc_target),
        .taken    (act_taken),
        .next_pc  (act_next_pc)
    );

    logic mispredict;
    assign mispredict = (upd_pred_taken != act_taken) ||
                        (act_taken && (upd_pred_target != calc_target));

    // Table write decision: wr_en with wr_valid=0 invalidates the slot.
    logic wr_en;
    logic wr_valid;
    ctr_t wr_ctr;

    always_comb begin
        wr_en    = 1'b0;
        wr_valid = 1'b0;
        wr_ctr   = SNT;
        case (cls)
            CLS_COND: begin
                if (u_hit) begin
                    wr_en    = 1'b1;
                    wr_valid = 1'b1;
                    wr_ctr   = ctr_step(ctr_q[u_idx], act_taken);
                end else if (act_taken) begin
                    wr_en    = 1'b1;
                    wr_valid = 1'b1;
                    wr_ctr   = WT;
                end
            end
            CLS_JUMP: begin
                wr_en    = 1'b1;
                wr_valid = 1'b1;
                wr_ctr   = ST;
            end
            CLS_JREG: begin
`ifdef BTB_JR_PREDICT_EN
                wr_en    = 1'b1;
                wr_valid = 1'b1;
                wr_ctr   = ST;
`else
                wr_en    = u_hit;
`endif
            end
            default: begin
                wr_en = u_hit;
            end
        endcase
    end

    // Lookup reads the table before this edge's write lands, giving
    // read-before-write for same-index lookup/update.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q        <= '0;
            pred_hit       <= 1'b0;
            pred_taken     <= 1'b0;
            pred_target    <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            pred_hit       <= l_hit;
            pred_taken     <= l_taken;
            pred_target    <= l_taken ? target_q[l_idx] : '0;
            redirect_valid <= upd_valid && mispredict;
            redirect_pc    <= (upd_valid && mispredict) ? act_next_pc : '0;
            if (upd_valid && wr_en) begin
                valid_q[u_idx]  <= wr_valid;
                tag_q[u_idx]    <= u_tag;
                target_q[u_idx] <= calc_target;
                ctr_q[u_idx]    <= wr_ctr;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// -----------------------------------------------------------------------------
// tb_branch_target_buffer
// Directed testbench for branch_target_buffer (ENTRIES=16). Honors
// BTB_JR_PREDICT_EN for the register-jump expectations.
// -----------------------------------------------------------------------------
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_instr;
    logic [31:0] upd_rs_data;
    logic        upd_taken;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int unsigned tests_run = 0;
    int unsigned tests_failed = 0;

    localparam logic [31:0] I_J    = 32'h0810_0040;  // j 0x00400100
    localparam logic [31:0] I_BEQ  = 32'h1000_FFFC;  // beq imm=-4
    localparam logic [31:0] I_JR   = 32'h03E0_0008;  // jr $ra
    localparam logic [31:0] I_NOP  = 32'h0000_0000;  // sll (non-control)

    always #5 clk = ~clk;

    branch_target_buffer #(.ENTRIES(16)) dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_valid     (fetch_valid),
        .fetch_pc        (fetch_pc),
        .pred_hit        (pred_hit),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_instr       (upd_instr),
        .upd_rs_data     (upd_rs_data),
        .upd_taken       (upd_taken),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge, then sample/drive 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_valid     = 1'b0;
        fetch_pc        = '0;
        upd_valid       = 1'b0;
        upd_pc          = '0;
        upd_instr       = '0;
        upd_rs_data     = '0;
        upd_taken       = 1'b0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = '0;
    endtask

    task automatic set_lookup(input logic [31:0] pc);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
    endtask

    task automatic set_update(input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] rs, input logic taken,
                              input logic ptaken, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_instr       = instr;
        upd_rs_data     = rs;
        upd_taken       = taken;
        upd_pred_taken  = ptaken;
        upd_pred_target = ptgt;
    endtask

    task automatic lookup_expect(input string tag, input logic [31:0] pc,
                                 input logic hit, input logic tk, input logic [31:0] tgt);
        idle();
        set_lookup(pc);
        tick();
        idle();
        check({tag, ".hit"},    {31'b0, pred_hit},   {31'b0, hit});
        check({tag, ".taken"},  {31'b0, pred_taken}, {31'b0, tk});
        check({tag, ".target"}, pred_target, tgt);
    endtask

    task automatic update_expect(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                                 input logic [31:0] rs, input logic taken, input logic ptaken,
                                 input logic [31:0] ptgt, input logic rv, input logic [31:0] rpc);
        idle();
        set_update(pc, instr, rs, taken, ptaken, ptgt);
        tick();
        idle();
        check({tag, ".rv"}, {31'b0, redirect_valid}, {31'b0, rv});
        check({tag, ".rpc"}, redirect_pc, rpc);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        check("rst.hit",    {31'b0, pred_hit},       32'd0);
        check("rst.taken",  {31'b0, pred_taken},     32'd0);
        check("rst.target", pred_target,             32'd0);
        check("rst.rv",     {31'b0, redirect_valid}, 32'd0);
        check("rst.rpc",    redirect_pc,             32'd0);
        rst = 1'b0;

        lookup_expect("cold", 32'h0040_0010, 1'b0, 1'b0, 32'h0);

        // J allocates with ST; redirect lasts one cycle
        update_expect("j", 32'h0040_0000, I_J, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_0100);
        tick();
        check("j.rv_drop", {31'b0, redirect_valid}, 32'd0);
        lookup_expect("j_lk", 32'h0040_0000, 1'b1, 1'b1, 32'h0040_0100);
        lookup_expect("tagmiss", 32'h0040_0040, 1'b0, 1'b0, 32'h0);
        idle();
        fetch_pc = 32'h0040_0000;
        tick();
        check("nofetch.hit", {31'b0, pred_hit}, 32'd0);

        // BEQ: taken miss allocates WT, then counter walks down and saturates
        update_expect("beq_t", 32'h0040_0020, I_BEQ, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0040_0014);
        lookup_expect("beq_wt", 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0014);
        // back-to-back not-taken updates: WT -> WNT -> SNT
        idle();
        set_update(32'h0040_0020, I_BEQ, 32'h0, 1'b0, 1'b1, 32'h0040_0014);
        tick();
        check("beq_nt1.rv",  {31'b0, redirect_valid}, 32'd1);
        check("beq_nt1.rpc", redirect_pc, 32'h0040_0028);
        set_update(32'h0040_0020, I_BEQ, 32'h0, 1'b0, 1'b1, 32'h0040_0014);
        tick();
        idle();
        check("beq_nt2.rv", {31'b0, redirect_valid}, 32'd1);
        lookup_expect("beq_snt", 32'h0040_0020, 1'b1, 1'b0, 32'h0);
        update_expect("beq_nt3", 32'h0040_0020, I_BEQ, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        // if it stayed at SNT, one taken step gives WNT (still not-taken)
        update_expect("beq_t2", 32'h0040_0020, I_BEQ, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0040_0014);
        lookup_expect("beq_wnt", 32'h0040_0020, 1'b1, 1'b0, 32'h0);
        update_expect("beq_t3", 32'h0040_0020, I_BEQ, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0040_0014);
        lookup_expect("beq_wt2", 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0014);

        // JR
        update_expect("jr1", 32'h0040_0030, I_JR, 32'h0040_1000, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_1000);
`ifdef BTB_JR_PREDICT_EN
        lookup_expect("jr_lk", 32'h0040_0030, 1'b1, 1'b1, 32'h0040_1000);
        update_expect("jr2", 32'h0040_0030, I_JR, 32'h0040_1000, 1'b0, 1'b1, 32'h0040_1000, 1'b0, 32'h0);
`else
        lookup_expect("jr_lk", 32'h0040_0030, 1'b0, 1'b0, 32'h0);
        update_expect("jr2", 32'h0040_0030, I_JR, 32'h0040_1000, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0040_1000);
`endif

        // Same-cycle lookup + invalidating update at index 0
        idle();
        set_lookup(32'h0040_0000);
        set_update(32'h0040_0000, I_NOP, 32'h0, 1'b0, 1'b1, 32'h0040_0100);
        tick();
        idle();
        check("rbw.hit",    {31'b0, pred_hit},       32'd1);
        check("rbw.taken",  {31'b0, pred_taken},     32'd1);
        check("rbw.target", pred_target,             32'h0040_0100);
        check("rbw.rv",     {31'b0, redirect_valid}, 32'd1);
        check("rbw.rpc",    redirect_pc,             32'h0040_0008);
        lookup_expect("rbw_after", 32'h0040_0000, 1'b0, 1'b0, 32'h0);

        // Reset coincident with a mispredicted update
        idle();
        set_update(32'h0040_0000, I_J, 32'h0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        tick();
        idle();
        check("rstfl.rv0", {31'b0, redirect_valid}, 32'd0);
        rst = 1'b0;
        tick();
        check("rstfl.rv1", {31'b0, redirect_valid}, 32'd0);
        lookup_expect("rstfl_j",   32'h0040_0000, 1'b0, 1'b0, 32'h0);
        lookup_expect("rstfl_beq", 32'h0040_0020, 1'b0, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
